mem_port: RTL
=============

# mem_port

Parametrised memory access unit holding the MAR and MDR and sequencing every RAM read and write through a small FSM with a configurable number of wait states. It sits between the CPU datapath bus and the external RAM, and replaces the fixed single-cycle MAR/MDR/RAM path. The control unit starts an access with a one-cycle request and waits for a `done` pulse, so it is insensitive to memory latency.

## Interface
Parameters:
- DATA_W, 32, bus, MDR and RAM data width
- ADDR_W, 9, RAM address width (MAR low bits driven to RAM)
- DEPTH, 512, number of implemented RAM words (≤ 2^ADDR_W)
- WAIT_STATES, 0, extra RAM cycles per access (0..15)

Ports:
- clock  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- clear  in  1  synchronous, active-high; same effect as reset at next edge
- bus_in  in  DATA_W  datapath bus (BusMuxOut)
- mar_in  in  1  load MAR from bus_in[ADDR_W-1:0]
- mdr_in  in  1  load MDR from bus_in
- start  in  1  begin access, one-cycle pulse
- mem_read  in  1  access type sampled with start (1 = read, 0 = write)
- busy  out  1  access in progress
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle range-error pulse (see Configuration)
- mdr_out  out  DATA_W  MDR contents to bus
- ram_addr  out  ADDR_W  RAM address (MAR)
- ram_wdata  out  DATA_W  RAM write data (MDR)
- ram_rdata  in  DATA_W  RAM read data
- ram_en  out  1  RAM chip enable
- ram_we  out  1  RAM write strobe

## Operation
- FSM states: IDLE, ACCESS, DONE. `busy` = (state == ACCESS).
- `start` is accepted in IDLE or DONE and ignored in ACCESS. Accepting it latches `mem_read` into a type flop, loads the wait counter with WAIT_STATES and enters ACCESS.
- ACCESS: `ram_en` = 1. While the counter > 0, each edge decrements it. At the edge where the counter == 0:
  - read: MDR ← ram_rdata
  - write: MDR unchanged
  - state → DONE
- `ram_we` = 1 only in the final ACCESS cycle (counter == 0) of a write.
- DONE: `done` = 1 for one cycle. The next state is ACCESS if `start` is asserted, otherwise IDLE.
- `mar_in` and `mdr_in` are honoured only when not busy; while busy they are ignored. If `mdr_in` and `start` arrive together, the MDR loads first and a write uses the new value.
- Loading MAR with `bus_in` bits wider than ADDR_W truncates the upper bits.
- Registered outputs: `mdr_out`, `ram_addr` and `ram_wdata` always reflect the MDR and MAR registers.

## Timing
- Latency from the edge sampling `start` (E0) to `done` high is WAIT_STATES+1 cycles. `done` is high between edges E(W+1) and E(W+2).
- Read data is available on `mdr_out` in the same cycle `done` is high.
- Back-to-back throughput is one access per WAIT_STATES+2 cycles.
- Reset values: state IDLE, MAR 0, MDR 0, counter 0. `busy`, `done`, `err`, `ram_en` and `ram_we` are all 0.
- Reset asserted mid-access: `ram_en` and `ram_we` drop immediately (asynchronously) and the access is abandoned with no `done`.
- `clear` mid-access: the same result, taking effect at the next edge.

## Configuration
- MEM_PORT_RANGE_CHECK_EN defined:
  - When `start` is accepted with MAR ≥ DEPTH, the FSM enters DONE directly (latency 1), `ram_en` and `ram_we` stay low, and `err` and `done` pulse together.
  - A read in this case loads MDR with 0.
- MEM_PORT_RANGE_CHECK_EN undefined:
  - No checking is done and `err` is tied 0.
  - The address wraps modulo 2^ADDR_W and all accesses take the normal path.

## Structure
- Package `mem_port_pkg`:
  - state enum (IDLE, ACCESS, DONE)
  - default width constants
  - WAIT_STATES counter width constant (4 bits)
- Sub-module `mem_port_fsm`: owns the state, the wait counter and the type flop, and produces `ram_en`, `ram_we`, `busy`, `done`, `err` and the MDR capture strobe.
- The top level holds the MAR and MDR registers and the bus muxing.

## Test plan
- Reset, then idle: all outputs 0. Load MAR = 0x005 and MDR = 0xDEADBEEF, then start a write with WAIT_STATES = 0.
  - Required: `ram_en` and `ram_we` high for exactly 1 cycle with ram_addr = 0x005 and ram_wdata = 0xDEADBEEF.
  - Required: `done` high 1 cycle later.
- WAIT_STATES = 3, read from MAR = 0x005 with RAM returning 0xDEADBEEF.
  - Required: `ram_en` high for 4 cycles, `ram_we` never high, and `done` at E4 with mdr_out = 0xDEADBEEF.
- Back-to-back: `start` asserted during DONE.
  - Required: the next ACCESS begins with no IDLE cycle, giving period WAIT_STATES+2.
- Reset pulsed low in the 2nd ACCESS cycle of a write (WAIT_STATES = 3).
  - Required: `ram_we` is never asserted, `done` never pulses, and MAR and MDR read 0.
- `mdr_in` asserted with bus_in = 0x12345678 while busy.
  - Required: MDR is unchanged. The same stimulus in IDLE loads the value.
- With MEM_PORT_RANGE_CHECK_EN and DEPTH = 256, read at MAR = 0x100.
  - Required: `err` and `done` pulse 1 cycle after `start`, `ram_en` stays 0, and mdr_out = 0.
  - Required without the macro: a normal access to address 0x100.

Source files
------------

// File: rtl/mem_port_pkg.sv
// Shared types and constants for the mem_port memory access unit.
// Holds the FSM state encoding, default widths and the wait-counter width.
package mem_port_pkg;

  localparam int DEF_DATA_W      = 32;
  localparam int DEF_ADDR_W      = 9;
  localparam int DEF_DEPTH       = 512;
  localparam int DEF_WAIT_STATES = 0;
  localparam int CNT_W           = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  // Wait-state count as loaded into the counter; values above 15 wrap.
  function automatic logic [CNT_W-1:0] wait_load(input int ws);
    return CNT_W'(ws);
  endfunction

endpackage

// File: rtl/mem_port_if.sv
// CPU-bus and RAM-side signal bundle of mem_port.
// The slave modport is the memory unit; the master modport is the CPU/RAM side.
interface mem_port_if
  import mem_port_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic [DATA_W-1:0] bus_in;
  logic              mar_in;
  logic              mdr_in;
  logic              start;
  logic              mem_read;
  logic              busy;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] mdr_out;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_en;
  logic              ram_we;

  modport slave (
    input  bus_in, mar_in, mdr_in, start, mem_read, ram_rdata,
    output busy, done, err, mdr_out, ram_addr, ram_wdata, ram_en, ram_we
  );

  modport master (
    output bus_in, mar_in, mdr_in, start, mem_read, ram_rdata,
    input  busy, done, err, mdr_out, ram_addr, ram_wdata, ram_en, ram_we
  );
endinterface

// File: rtl/mem_port_fsm.sv
// Access sequencer for mem_port: state, wait counter, access-type flop and RAM strobes.
// Optional range checking is enabled by defining MEM_PORT_RANGE_CHECK_EN.
module mem_port_fsm
  import mem_port_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int WAIT_STATES = DEF_WAIT_STATES
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              start_i,
  input  logic              mem_read_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic              mdr_cap_o,
  output logic              mdr_zero_o
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rd_q, rd_d;
  logic             err_q, err_d;
  logic             oor;

`ifdef MEM_PORT_RANGE_CHECK_EN
  assign oor = (32'(addr_i) >= 32'(DEPTH));
`else
  localparam int unused_depth = DEPTH;
  logic unused_addr;
  assign unused_addr = ^addr_i;
  assign oor         = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_d       = rd_q;
    err_d      = 1'b0;
    ram_en_o   = 1'b0;
    ram_we_o   = 1'b0;
    mdr_cap_o  = 1'b0;
    mdr_zero_o = 1'b0;
    case (state_q)
      ACCESS: begin
        ram_en_o = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d   = DONE;
          ram_we_o  = !rd_q;
          mdr_cap_o = rd_q;
        end
      end
      default: begin
        // IDLE and DONE both accept a new request; DONE chains straight into ACCESS.
        state_d = IDLE;
        if (start_i) begin
          rd_d = mem_read_i;
          if (oor) begin
            state_d    = DONE;
            err_d      = 1'b1;
            cnt_d      = '0;
            mdr_zero_o = mem_read_i;
          end else begin
            state_d = ACCESS;
            cnt_d   = wait_load(WAIT_STATES);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      err_q   <= 1'b0;
    end else if (clear_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
    end
  end

  assign busy_o = (state_q == ACCESS);
  assign done_o = (state_q == DONE);
  assign err_o  = err_q;

endmodule

// File: rtl/mem_port.sv
// Memory access unit: MAR/MDR registers and bus muxing around the access sequencer.
// Range checking against DEPTH is enabled by defining MEM_PORT_RANGE_CHECK_EN.
module mem_port
  import mem_port_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int WAIT_STATES = DEF_WAIT_STATES
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      clear,
  mem_port_if.slave bus
);

  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic              busy;
  logic              mdr_cap;
  logic              mdr_zero;

  // The range check sees the MAR value held before this edge's load.
  mem_port_fsm #(
    .ADDR_W      (ADDR_W),
    .DEPTH       (DEPTH),
    .WAIT_STATES (WAIT_STATES)
  ) u_fsm (
    .clock      (clock),
    .reset      (reset),
    .clear_i    (clear),
    .start_i    (bus.start),
    .mem_read_i (bus.mem_read),
    .addr_i     (mar_q),
    .busy_o     (busy),
    .done_o     (bus.done),
    .err_o      (bus.err),
    .ram_en_o   (bus.ram_en),
    .ram_we_o   (bus.ram_we),
    .mdr_cap_o  (mdr_cap),
    .mdr_zero_o (mdr_zero)
  );

  always_comb begin
    mar_d = mar_q;
    if (bus.mar_in && !busy) begin
      mar_d = bus.bus_in[ADDR_W-1:0];
    end
    mdr_d = mdr_q;
    if (mdr_zero) begin
      mdr_d = '0;
    end else if (mdr_cap) begin
      mdr_d = bus.ram_rdata;
    end else if (bus.mdr_in && !busy) begin
      mdr_d = bus.bus_in;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mar_q <= '0;
      mdr_q <= '0;
    end else if (clear) begin
      mar_q <= '0;
      mdr_q <= '0;
    end else begin
      mar_q <= mar_d;
      mdr_q <= mdr_d;
    end
  end

  assign bus.busy      = busy;
  assign bus.mdr_out   = mdr_q;
  assign bus.ram_addr  = mar_q;
  assign bus.ram_wdata = mdr_q;

endmodule
